cmem_loader: RTL and testbench

CMEM_LOADER -- requirements
Module: cmem_loader

---
 rtl/myfilter_pkg.sv | 14 +
 rtl/cmem_loader_if.sv | 28 ++
 rtl/cmem_loader.sv | 99 +++++++++
 tb/tb_cmem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared filter constants and the coefficient-loader state encoding.
package myfilter_pkg;

    localparam int CMEMSIZE = 4;
    localparam int DATABITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cmem_ld_state_t;

endpackage

// File: rtl/cmem_loader_if.sv
// Bundle of the loader's control, word-stream and serial-memory signals.
interface cmem_loader_if
    import myfilter_pkg::*;
#(
    parameter int CMEMSIZE = myfilter_pkg::CMEMSIZE,
    parameter int DATABITS = myfilter_pkg::DATABITS
);
    logic                             start;
    logic                             abort;
    logic                             coef_valid;
    logic [DATABITS-1:0]              coef;
    logic                             coef_ready;
    logic                             sde;
    logic                             sd;
    logic                             busy;
    logic                             done;
    logic [$clog2(CMEMSIZE+1)-1:0]    word_cnt;

    modport master (
        output start, abort, coef_valid, coef,
        input  coef_ready, sde, sd, busy, done, word_cnt
    );

    modport slave (
        input  start, abort, coef_valid, coef,
        output coef_ready, sde, sd, busy, done, word_cnt
    );
endinterface

// File: rtl/cmem_loader.sv
// Accepts CMEMSIZE coefficient words over a valid/ready stream and shifts each
// one MSB-first into a serial coefficient memory.
module cmem_loader
    import myfilter_pkg::*;
#(
    parameter int CMEMSIZE = myfilter_pkg::CMEMSIZE,
    parameter int DATABITS = myfilter_pkg::DATABITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_in,
    input  logic                          abort_in,
    input  logic                          coef_valid_in,
    input  logic [DATABITS-1:0]           coef_in,
    output logic                          coef_ready_out,
    output logic                          sde_out,
    output logic                          sd_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic [$clog2(CMEMSIZE+1)-1:0] word_cnt_out
);

    localparam int CNTW = $clog2(CMEMSIZE + 1);
    localparam int BITW = (DATABITS > 1) ? $clog2(DATABITS) : 1;

    cmem_ld_state_t      state_q, state_d;
    logic [DATABITS-1:0] shreg_q, shreg_d;
    logic [BITW-1:0]     bitcnt_q, bitcnt_d;
    logic [CNTW-1:0]     wcnt_q, wcnt_d;
    logic [CNTW-1:0]     wcnt_inc;

    assign wcnt_inc = wcnt_q + CNTW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Abort is tested first in every active state so it beats a same-cycle handshake.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            IDLE: begin
                if (start_in && !abort_in) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (coef_valid_in) begin
                    shreg_d  = coef_in;
                    bitcnt_d = BITW'(DATABITS - 1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - BITW'(1);
                    if (bitcnt_q == '0) begin
                        wcnt_d  = wcnt_inc;
                        state_d = (wcnt_inc == CNTW'(CMEMSIZE)) ? DONE : WAIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs come straight from state and datapath registers.
    assign coef_ready_out = (state_q == WAIT);
    assign sde_out        = (state_q == SHIFT);
    assign sd_out         = (state_q == SHIFT) && shreg_q[DATABITS-1];
    assign busy_out       = (state_q != IDLE);
    assign done_out       = (state_q == DONE);
    assign word_cnt_out   = wcnt_q;

endmodule

// File: tb/tb_cmem_loader.sv
// Randomised bench for cmem_loader driving a serial coefficient memory model;
// expectations come from a per-word timing schedule and the address-order rule.
module tb_cmem_loader;
    import myfilter_pkg::*;

    localparam int NW = CMEMSIZE;
    localparam int DB = DATABITS;
    localparam int CW = $clog2(NW + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmem_loader_if bus ();

    cmem_loader dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (bus.start),
        .abort_in       (bus.abort),
        .coef_valid_in  (bus.coef_valid),
        .coef_in        (bus.coef),
        .coef_ready_out (bus.coef_ready),
        .sde_out        (bus.sde),
        .sd_out         (bus.sd),
        .busy_out       (bus.busy),
        .done_out       (bus.done),
        .word_cnt_out   (bus.word_cnt)
    );

    // Serial coefficient memory: one long shift chain, address a occupies bits [a*DB +: DB].
    logic [NW*DB-1:0] cmem_q = '0;
    always @(posedge clk) begin
        if (bus.sde) cmem_q <= {cmem_q[NW*DB-2:0], bus.sd};
    end

    int n_checks = 0;
    int n_errors = 0;
    int sess_no  = 0;

    logic [DB-1:0] words [NW];
    int            gaps  [NW];
    int            c_end [NW];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word i: gaps[i] stall cycles, one handshake edge, then DB shift edges.
    function automatic int schedule();
        int s = 1;
        for (int i = 0; i < NW; i++) begin
            c_end[i] = s + gaps[i] + DB;
            s        = c_end[i] + 1;
        end
        return c_end[NW-1];
    endfunction

    task automatic run_session(input int abort_at, input int rst_at, input bit noise, input string name);
        int exp_done, exp_cnt, gap_sum, idx, gap_rem;
        int sde_n, rdy_n, busy_n, done_n, done_edge, sd_bad, late_done;
        bit stop;
        logic [DB-1:0] got_w;
        exp_done = schedule();
        gap_sum  = 0;
        for (int i = 0; i < NW; i++) gap_sum += gaps[i];
        exp_cnt = 0;
        for (int i = 0; i < NW; i++) if (c_end[i] < abort_at) exp_cnt++;
        idx = 0; gap_rem = gaps[0];
        sde_n = 0; rdy_n = 0; busy_n = 0; done_n = 0; done_edge = -1; sd_bad = 0;
        stop = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b0; bus.coef_valid = 1'b0;
        for (int k = 0; k <= exp_done + 2 && !stop; k++) begin
            @(posedge clk); #1;
            if (abort_at != 0 && k == abort_at) begin
                bus.abort = 1'b0;
                check_val({name, "_abort_busy"}, 32'(bus.busy), 32'd0);
                check_val({name, "_abort_sde"},  32'(bus.sde),  32'd0);
                check_val({name, "_abort_wcnt"}, 32'(bus.word_cnt), 32'(exp_cnt));
                stop = 1'b1;
            end else if (rst_at != 0 && k == rst_at) begin
                rst = 1'b0;
                check_val({name, "_rst_outs"},
                          32'({bus.coef_ready, bus.sde, bus.sd, bus.busy, bus.done, bus.word_cnt}), 32'd0);
                stop = 1'b1;
            end else begin
                sde_n  += int'(bus.sde);
                rdy_n  += int'(bus.coef_ready);
                busy_n += int'(bus.busy);
                if (!bus.sde && bus.sd) sd_bad++;
                if (bus.done) begin
                    done_n++;
                    if (done_edge < 0) done_edge = k;
                end
                bus.start = (noise && k < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.abort = (abort_at != 0 && k + 1 == abort_at);
                rst       = (rst_at != 0 && k + 1 == rst_at);
                if (bus.coef_ready) begin
                    if (gap_rem > 0 || idx >= NW) begin
                        bus.coef_valid = 1'b0;
                        if (gap_rem > 0) gap_rem--;
                    end else begin
                        bus.coef_valid = 1'b1;
                        bus.coef       = words[idx];
                        idx++;
                        gap_rem = (idx < NW) ? gaps[idx] : 0;
                    end
                end else begin
                    bus.coef_valid = 1'($urandom_range(0, 1));
                    bus.coef       = DB'($urandom);
                end
            end
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.coef_valid = 1'b0; rst = 1'b0;
        if (abort_at != 0 || rst_at != 0) begin
            late_done = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                late_done += int'(bus.done);
            end
            check_val({name, "_no_done"}, 32'(late_done), 32'd0);
        end else begin
            check_val({name, "_done_edge"}, 32'(done_edge), 32'(exp_done));
            check_val({name, "_done_width"}, 32'(done_n), 32'd1);
            check_val({name, "_sde_cycles"}, 32'(sde_n), 32'(NW * DB));
            check_val({name, "_ready_cycles"}, 32'(rdy_n), 32'(gap_sum + NW));
            check_val({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_done + 1));
            check_val({name, "_sd_idle"}, 32'(sd_bad), 32'd0);
            check_val({name, "_wcnt"}, 32'(bus.word_cnt), 32'(NW));
            for (int i = 0; i < NW; i++) begin
                got_w = cmem_q[(NW-1-i)*DB +: DB];
                check_val($sformatf("%s_mem%0d", name, NW-1-i), 32'(got_w), 32'(words[i]));
            end
        end
        sess_no++;
        $display("session %0d %s: abort_at=%0d rst_at=%0d noise=%0d expected_done_edge=%0d",
                 sess_no, name, abort_at, rst_at, noise, exp_done);
    endtask

    initial begin
        int mode, ed;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.coef_valid = 1'b0; bus.coef = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(bus.coef_ready), 32'd0);
        check_val("rst_sde",   32'(bus.sde),  32'd0);
        check_val("rst_sd",    32'(bus.sd),   32'd0);
        check_val("rst_busy",  32'(bus.busy), 32'd0);
        check_val("rst_done",  32'(bus.done), 32'd0);
        check_val("rst_wcnt",  32'(bus.word_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_outs",
                  32'({bus.coef_ready, bus.sde, bus.sd, bus.busy, bus.done, bus.word_cnt}), 32'd0);

        // Back-to-back words, valid always offered.
        for (int i = 0; i < NW; i++) begin
            words[i] = DB'(8'h11 * (i + 1));
            gaps[i]  = 0;
        end
        run_session(0, 0, 1'b0, "basic");

        // Five-cycle stall before word 2.
        gaps[2] = 5;
        run_session(0, 0, 1'b0, "stall");
        gaps[2] = 0;

        // Abort on the edge that shifts the 4th bit of word 1.
        run_session(c_end[0] + 5, 0, 1'b0, "abort_w1");

        // Reset part way through shifting word 2, then reload 0xA5.
        void'(schedule());
        run_session(0, c_end[2] - 4, 1'b0, "rst_w2");
        for (int i = 0; i < NW; i++) words[i] = DB'(8'hA5);
        run_session(0, 0, 1'b0, "reload_a5");

        // start together with abort in IDLE must be ignored.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check_val("start_abort_idle_busy",  32'(bus.busy), 32'd0);
        check_val("start_abort_idle_ready", 32'(bus.coef_ready), 32'd0);
        @(posedge clk); #1;
        check_val("start_abort_idle_busy2", 32'(bus.busy), 32'd0);

        // start toggling while busy, plus random valid on non-WAIT cycles.
        for (int i = 0; i < NW; i++) words[i] = DB'($urandom);
        run_session(0, 0, 1'b1, "start_noise");

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NW; i++) begin
                words[i] = DB'($urandom);
                gaps[i]  = int'($urandom_range(0, 3));
            end
            ed   = schedule();
            mode = int'($urandom_range(0, 2));
            if (mode == 1)
                run_session(int'($urandom_range(1, ed)), 0, 1'($urandom_range(0, 1)), "rand_abort");
            else if (mode == 2)
                run_session(0, int'($urandom_range(1, ed)), 1'($urandom_range(0, 1)), "rand_rst");
            else
                run_session(0, 0, 1'($urandom_range(0, 1)), "rand_full");
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
